// File: rtl/pc_unit_if.sv
// Fetch-control bundle between the decode/control unit (master) and pc_unit (slave).
interface pc_unit_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic [1:0]       pc_sel;
    logic             branch_taken;
    logic [WIDTH-1:0] offset;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] reg_target;
    logic             link;
    logic             ret;
    logic             exc_req;
    logic             eret;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] epc_out;
    logic             in_exc;
    logic             addr_fault;
    logic             ras_empty;

    modport master (
        output stall, pc_sel, branch_taken, offset, jump_target, reg_target,
        output link, ret, exc_req, eret,
        input  pc_out, pc_plus4, epc_out, in_exc, addr_fault, ras_empty
    );

    modport slave (
        input  stall, pc_sel, branch_taken, offset, jump_target, reg_target,
        input  link, ret, exc_req, eret,
        output pc_out, pc_plus4, epc_out, in_exc, addr_fault, ras_empty
    );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection, stall, misaligned-target faulting, exceptions/eret.
// Optional return-address stack is built when the macro PC_RAS_EN is defined.
module pc_unit #(
    parameter int WIDTH      = 32,
    parameter     RESET_ADDR = 0,
    parameter     EXC_VECTOR = 32'h0000_0080,
    parameter int RAS_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    pc_unit_if.slave   bus
);
    localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_ADDR);
    localparam logic [WIDTH-1:0] EXC_PC   = WIDTH'(EXC_VECTOR);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             in_exc_q, in_exc_d;
    logic             addr_fault_q, addr_fault_d;

    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] branch_off;
    logic [WIDTH-1:0] branch_tgt;
    logic [WIDTH-1:0] candidate;
    logic [WIDTH-1:0] ras_top;
    logic             ras_hit;
    logic             fault;
    logic             take_exc;
    logic             do_eret;
    logic             ras_update;

    assign pc_plus4   = pc_q + WIDTH'(4);
    assign branch_off = bus.offset << 2;
    assign branch_tgt = pc_plus4 + branch_off;

    always_comb begin
        candidate = pc_plus4;
        case (bus.pc_sel)
            2'b00:   candidate = pc_plus4;
            2'b01:   candidate = bus.branch_taken ? branch_tgt : pc_plus4;
            2'b10:   candidate = bus.jump_target;
            default: candidate = ras_hit ? ras_top : bus.reg_target;
        endcase
    end

    // Branch targets are always word aligned, so only the jump forms can fault.
    assign fault      = bus.pc_sel[1] && (candidate[1:0] != 2'b00);
    assign take_exc   = bus.exc_req || fault;
    assign do_eret    = !take_exc && bus.eret && in_exc_q;
    assign ras_update = !take_exc && !do_eret && !bus.stall && bus.pc_sel[1];

    always_comb begin
        pc_d         = pc_q;
        epc_d        = epc_q;
        in_exc_d     = in_exc_q;
        addr_fault_d = 1'b0;
        if (take_exc) begin
            pc_d         = EXC_PC;
            in_exc_d     = 1'b1;
            addr_fault_d = fault;
            if (!in_exc_q) begin
                epc_d = pc_q;
            end
        end else if (do_eret) begin
            pc_d     = epc_q;
            in_exc_d = 1'b0;
        end else if (!bus.stall) begin
            pc_d = candidate;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            epc_q        <= '0;
            in_exc_q     <= 1'b0;
            addr_fault_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            epc_q        <= epc_d;
            in_exc_q     <= in_exc_d;
            addr_fault_q <= addr_fault_d;
        end
    end

`ifdef PC_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_d [RAS_DEPTH];
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_pop;
    logic             do_push;
    logic [PTR_W-1:0] pop_top;
    logic [CNT_W-1:0] pop_cnt;
    logic [PTR_W-1:0] push_idx;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RAS_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_prev(input logic [PTR_W-1:0] p);
        return (p == '0) ? PTR_W'(RAS_DEPTH - 1) : p - PTR_W'(1);
    endfunction

    assign ras_top = ras_q[top_q];
    assign ras_hit = bus.ret && (cnt_q != '0);
    assign do_pop  = ras_update && (bus.pc_sel == 2'b11) && ras_hit;
    assign do_push = ras_update && bus.link;

    // Pop happens before push, so link+ret replaces the top in place; a push
    // onto a full stack lands on the oldest slot because the buffer is circular.
    always_comb begin
        ras_d    = ras_q;
        pop_top  = do_pop ? ptr_prev(top_q) : top_q;
        pop_cnt  = do_pop ? cnt_q - CNT_W'(1) : cnt_q;
        push_idx = ptr_next(pop_top);
        top_d    = pop_top;
        cnt_d    = pop_cnt;
        if (do_push) begin
            ras_d[push_idx] = pc_plus4;
            top_d           = push_idx;
            if (pop_cnt != CNT_W'(RAS_DEPTH)) begin
                cnt_d = pop_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            ras_q <= ras_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.ras_empty = (cnt_q == '0);
`else
    logic unused_ras;

    assign ras_top       = '0;
    assign ras_hit       = 1'b0;
    assign unused_ras    = ^{bus.link, bus.ret, ras_update};
    assign bus.ras_empty = 1'b1;
`endif

    assign bus.pc_out     = pc_q;
    assign bus.pc_plus4   = pc_plus4;
    assign bus.epc_out    = epc_q;
    assign bus.in_exc     = in_exc_q;
    assign bus.addr_fault = addr_fault_q;
endmodule

// File: tb/tb_pc_unit.sv
// Directed, table-driven bench for pc_unit with hand sequences for reset and the return-address stack.
module tb_pc_unit;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    pc_unit_if #(.WIDTH(32)) bus ();

    pc_unit #(
        .WIDTH(32),
        .RESET_ADDR(0),
        .EXC_VECTOR(32'h0000_0080),
        .RAS_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic [1:0]  sel;
        logic        taken;
        logic [31:0] offset;
        logic [31:0] jt;
        logic [31:0] rt;
        logic        link;
        logic        ret;
        logic        exc;
        logic        eret;
        logic [31:0] exp_pc;
        logic [31:0] exp_epc;
        logic        exp_in_exc;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic [1:0] sel, input logic tk,
                                input logic [31:0] off, input logic [31:0] jt, input logic [31:0] rt,
                                input logic lk, input logic rtn, input logic exc, input logic er,
                                input logic [31:0] pc, input logic [31:0] epc,
                                input logic inx, input logic af);
        vec_t v;
        v.stall = st; v.sel = sel; v.taken = tk; v.offset = off; v.jt = jt; v.rt = rt;
        v.link = lk; v.ret = rtn; v.exc = exc; v.eret = er;
        v.exp_pc = pc; v.exp_epc = epc; v.exp_in_exc = inx; v.exp_fault = af;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic driveIdle();
        bus.stall = 1'b0; bus.pc_sel = 2'b00; bus.branch_taken = 1'b0;
        bus.offset = '0; bus.jump_target = '0; bus.reg_target = '0;
        bus.link = 1'b0; bus.ret = 1'b0; bus.exc_req = 1'b0; bus.eret = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.stall = v.stall; bus.pc_sel = v.sel; bus.branch_taken = v.taken;
        bus.offset = v.offset; bus.jump_target = v.jt; bus.reg_target = v.rt;
        bus.link = v.link; bus.ret = v.ret; bus.exc_req = v.exc; bus.eret = v.eret;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        driveIdle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [31:0] ret_exp [5];
    logic [31:0] combo_exp [2];
    logic        exp_empty_after_calls;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        driveIdle();

        // Vectors run back to back from reset; expectations are the state after each edge.
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hC, 32'h0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'hFFFF_FFFE, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFC, 32'h0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'hFFFF_FFFE, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104, 32'h0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104, 32'h0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80, 32'h40, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h84, 32'h40, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80, 32'h40, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h40, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44, 32'h40, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0, 32'h202, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 32'h44, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h84, 32'h44, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44, 32'h44, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h301, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 32'h44, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44, 32'h44, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h3, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h54, 32'h44, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 32'h200, 32'h44, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0, 32'h203, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 32'h200, 1'b1, 1'b1));

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_pc", bus.pc_out, 32'h0);
        checkOutput("reset_epc", bus.epc_out, 32'h0);
        checkOutput("reset_in_exc", 32'(bus.in_exc), 32'h0);
        checkOutput("reset_fault", 32'(bus.addr_fault), 32'h0);
        checkOutput("reset_ras_empty", 32'(bus.ras_empty), 32'h1);
        checkOutput("reset_pc_plus4", bus.pc_plus4, 32'h4);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_pc", i), bus.pc_out, vecs[i].exp_pc);
            checkOutput($sformatf("vec%0d_epc", i), bus.epc_out, vecs[i].exp_epc);
            checkOutput($sformatf("vec%0d_in_exc", i), 32'(bus.in_exc), 32'(vecs[i].exp_in_exc));
            checkOutput($sformatf("vec%0d_fault", i), 32'(bus.addr_fault), 32'(vecs[i].exp_fault));
            checkOutput($sformatf("vec%0d_pc_plus4", i), bus.pc_plus4, vecs[i].exp_pc + 32'd4);
        end

        // Asynchronous reset while in the handler at PC 0x80 (entered from 0x10).
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(mk(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0));
        end
        checkOutput("midrun_pc_before", bus.pc_out, 32'h10);
        applyStimulus(mk(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0));
        checkOutput("midrun_epc_before", bus.epc_out, 32'h10);
        driveIdle();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrun_reset_pc", bus.pc_out, 32'h0);
        checkOutput("midrun_reset_epc", bus.epc_out, 32'h0);
        checkOutput("midrun_reset_in_exc", 32'(bus.in_exc), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("first_fetch_pc", bus.pc_out, 32'h0);
        applyStimulus(mk(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0));
        checkOutput("after_reset_seq_pc", bus.pc_out, 32'h4);

        // Return-address stack: five calls into a depth-4 stack, then five returns.
`ifdef PC_RAS_EN
        ret_exp = '{32'h4004, 32'h3004, 32'h2004, 32'h1004, 32'h999C};
        combo_exp = '{32'h99A0, 32'h6004};
        exp_empty_after_calls = 1'b0;
`else
        ret_exp = '{32'h999C, 32'h999C, 32'h999C, 32'h999C, 32'h999C};
        combo_exp = '{32'h7000, 32'h7000};
        exp_empty_after_calls = 1'b1;
`endif
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(mk(1'b0, 2'b10, 1'b0, 32'h0, 32'(32'h1000 * (i + 1)), 32'h0,
                             1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0));
            checkOutput($sformatf("call%0d_pc", i), bus.pc_out, 32'(32'h1000 * (i + 1)));
        end
        checkOutput("ras_empty_after_calls", 32'(bus.ras_empty), 32'(exp_empty_after_calls));
        for (int i = 0; i < 5; i++) begin
            applyStimulus(mk(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h999C,
                             1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0));
            checkOutput($sformatf("ret%0d_pc", i), bus.pc_out, ret_exp[i]);
        end
        checkOutput("ras_empty_after_rets", 32'(bus.ras_empty), 32'h1);

        // Call, then a combined link+ret that replaces the top, then a plain return.
        applyStimulus(mk(1'b0, 2'b10, 1'b0, 32'h0, 32'h6000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0));
        checkOutput("combo_call_pc", bus.pc_out, 32'h6000);
        applyStimulus(mk(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h7000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0));
        checkOutput("combo_linkret_pc", bus.pc_out, combo_exp[0]);
        checkOutput("combo_ras_empty", 32'(bus.ras_empty), 32'(exp_empty_after_calls));
        applyStimulus(mk(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h7000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0));
        checkOutput("combo_ret_pc", bus.pc_out, combo_exp[1]);
        checkOutput("combo_ras_empty_end", 32'(bus.ras_empty), 32'h1);

        driveIdle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the single-cycle and pipelined MIPS-style datapaths. It holds the current fetch address and computes the next address internally: sequential, taken branch, absolute jump and register jump. It adds stall hold, misaligned-target faulting, exception vectoring with EPC capture and return-from-exception. An optional return-address stack predicts register-jump returns. It sits at the head of the fetch stage, drives instruction memory, and takes control inputs from the decode/control unit.

## Interface
- WIDTH, 32, address width; must be at least 8.
- RESET_ADDR, 0, PC value loaded on reset; word aligned.
- EXC_VECTOR, 32'h0000_0080, exception handler address, truncated to WIDTH; word aligned.
- RAS_DEPTH, 4, return-address stack entries; valid range 2..16. Used only with PC_RAS_EN.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- stall  in  1  hold the PC; suppresses push/pop.
- pc_sel  in  2  next-PC source: 00 = sequential, 01 = branch, 10 = absolute jump, 11 = register jump.
- branch_taken  in  1  branch condition; used only when pc_sel = 01.
- offset  in  WIDTH  signed word offset (already sign-extended).
- jump_target  in  WIDTH  absolute target for pc_sel = 10.
- reg_target  in  WIDTH  register value for pc_sel = 11.
- link  in  1  with pc_sel = 10 or 11: the jump is a call; push pc_plus4.
- ret  in  1  with pc_sel = 11: the jump is a return; pop the RAS.
- exc_req  in  1  take an exception this cycle.
- eret  in  1  return from exception.
- pc_out  out  WIDTH  current PC, registered.
- pc_plus4  out  WIDTH  pc_out + 4 modulo 2^WIDTH, combinational.
- epc_out  out  WIDTH  saved exception PC, registered.
- in_exc  out  1  handler-mode flag, registered.
- addr_fault  out  1  one-cycle registered pulse: a misaligned target was faulted.
- ras_empty  out  1  RAS holds no entries.

## Operation
- Reset values:
  - pc_out = RESET_ADDR.
  - epc_out = 0, in_exc = 0, addr_fault = 0.
  - RAS count = 0, so ras_empty = 1.
- Candidate target per pc_sel:
  - 00: pc_plus4.
  - 01: pc_plus4 + (offset << 2) if branch_taken, else pc_plus4.
  - 10: jump_target.
  - 11: RAS top if ret is set and the RAS is non-empty; otherwise reg_target.
- All arithmetic is WIDTH bits, unsigned modulo. Overflow wraps silently; 0xFFFF_FFFC + 4 = 0.
- Fault: the candidate target has bits [1:0] != 0. Only pc_sel 10 and 11 can fault.
- Priority, highest first:
  1. exc_req or fault: pc_out ← EXC_VECTOR and in_exc ← 1. epc_out ← pc_out only if in_exc was 0; a nested exception keeps the original EPC. addr_fault ← 1 on the next cycle if the cause was a fault. Overrides stall. No RAS push or pop.
  2. eret with in_exc = 1: pc_out ← epc_out and in_exc ← 0. eret with in_exc = 0 is ignored and falls through to the rules below.
  3. stall: all state holds.
  4. Otherwise: pc_out ← candidate target.
- RAS, when taking a non-faulting jump with stall = 0 and no exception:
  - link = 1 pushes pc_plus4.
  - ret = 1 (pc_sel = 11) pops.
  - link and ret together: pop, then push the same cycle. Net count is unchanged and the top is replaced by pc_plus4.
  - Push when full: circular overwrite of the oldest entry; count saturates at RAS_DEPTH.
  - Pop when empty: no change, and reg_target is used.

## Timing
- Registered outputs change only on the rising clk edge after the request, or asynchronously on reset.
- pc_plus4 and the fault decision are combinational, valid in the same cycle as their inputs.
- Redirect latency: 1 cycle. An input sampled at edge N shows on pc_out after edge N.
- addr_fault is high for exactly one cycle, the one after the faulting edge.
- Reset asserted mid-operation: all state returns to its reset values immediately. The first fetch after deassertion is RESET_ADDR.

## Configuration
- PC_RAS_EN defined: the return-address stack is built as described above.
- PC_RAS_EN undefined:
  - No storage is built.
  - link and ret are ignored.
  - pc_sel = 11 always uses reg_target.
  - ras_empty is tied to 1.

## Test plan
- Reset, then 3 cycles of pc_sel = 00 → pc_out reads 0, 4, 8, C. Assert reset mid-run at PC = 0x10 → pc_out = 0 immediately.
- At PC = 0x100: pc_sel = 01, offset = -2, taken → 0xFC. Same request with taken = 0 → 0x104. At PC = 0xFFFF_FFFC, sequential → 0.
- jump_target = 0x202 → pc_out = 0x80, epc_out = old PC, addr_fault high for 1 cycle, in_exc = 1. Then eret → pc_out = old PC, in_exc = 0.
- exc_req together with stall at PC = 0x40 → vectors to 0x80 with epc_out = 0x40. A second exc_req in the handler keeps epc_out = 0x40.
- PC_RAS_EN, RAS_DEPTH = 4:
  - 5 link calls, then 5 returns with reg_target = 0x999C → first 4 returns pop newest-first, the 5th uses 0x999C, and ras_empty = 1.
  - Without the macro, the same returns all go to 0x999C.
